// File: rtl/mem_store_buffer_lsu.sv
// Memory stage with a posted store buffer, store-to-load forwarding
// and IO loads ordered behind buffered stores.
module mem_store_buffer_lsu #(
  parameter int          SB_DEPTH = 4,
  parameter logic [31:0] IO_BASE  = 32'h30000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [3:0]  cmdtype,
  input  logic [4:0]  input_rd_addr,
  input  logic [31:0] input_rd_data,
  input  logic        write_or_not,
  input  logic [31:0] mem_addr,
  input  logic [31:0] storedata_in,
  output logic [4:0]  out_rd_addr,
  output logic [31:0] out_rd_data,
  output logic        out_write_or_not,
  output logic        stall_from_mem,
  output logic        sb_empty,
  input  logic        mem_load_done,
  input  logic [1:0]  mem_ctrl_busy_state,
  input  logic [31:0] mem_ctrl_read_in,
  output logic        read_mem,
  output logic        write_mem,
  output logic [31:0] mem_addr_to_read,
  output logic [31:0] mem_data_to_write,
  output logic [2:0]  data_len
);
  localparam int PW = $clog2(SB_DEPTH);

  localparam logic [3:0] C_LB  = 4'd1;
  localparam logic [3:0] C_LH  = 4'd2;
  localparam logic [3:0] C_LW  = 4'd3;
  localparam logic [3:0] C_LBU = 4'd4;
  localparam logic [3:0] C_LHU = 4'd5;
  localparam logic [3:0] C_SB  = 4'd6;
  localparam logic [3:0] C_SH  = 4'd7;
  localparam logic [3:0] C_SW  = 4'd8;

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, STORE_WAIT} state_t;

  state_t      state;
  logic [31:0] sb_addr [SB_DEPTH];
  logic [31:0] sb_data [SB_DEPTH];
  logic [2:0]  sb_size [SB_DEPTH];
  logic [PW-1:0] head, tail, idx;
  logic [PW:0] count;
  logic        load_valid;
  logic [31:0] result;
  logic [3:0]  ld_cmd;

  logic        is_load, is_store, io, busy;
  logic [2:0]  ld_size, st_size;
  logic [32:0] ld_lo, ld_hi, e_lo, e_hi;
  logic        hit, fwd_ok, can_fwd, blocked;
  logic [31:0] fwd_data;
  logic        want_issue, load_go, drain_go, push, pop;

  function automatic logic [31:0] ext(input logic [3:0] c,
                                      input logic [31:0] d);
    case (c)
      C_LB:    return {{24{d[7]}}, d[7:0]};
      C_LH:    return {{16{d[15]}}, d[15:0]};
      C_LBU:   return {24'd0, d[7:0]};
      C_LHU:   return {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign sb_empty = (count == '0);
  assign busy     = mem_ctrl_busy_state[1];
  assign is_load  = cmdtype inside {C_LB, C_LH, C_LW, C_LBU, C_LHU};
  assign is_store = cmdtype inside {C_SB, C_SH, C_SW};
  assign io       = mem_addr >= IO_BASE;

  always_comb begin
    ld_size = 3'd4;
    if (cmdtype inside {C_LB, C_LBU}) ld_size = 3'd1;
    if (cmdtype inside {C_LH, C_LHU}) ld_size = 3'd2;
    st_size = 3'd4;
    if (cmdtype == C_SB) st_size = 3'd1;
    if (cmdtype == C_SH) st_size = 3'd2;
  end

  // Oldest to youngest, so the youngest overlapping entry decides.
  always_comb begin
    hit      = 1'b0;
    fwd_ok   = 1'b0;
    fwd_data = '0;
    idx      = '0;
    e_lo     = '0;
    e_hi     = '0;
    ld_lo    = {1'b0, mem_addr};
    ld_hi    = ld_lo + 33'(ld_size);
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = head + PW'(i);
      if ((PW+1)'(i) < count) begin
        e_lo = {1'b0, sb_addr[idx]};
        e_hi = e_lo + 33'(sb_size[idx]);
        if (e_lo < ld_hi && ld_lo < e_hi) begin
          hit      = 1'b1;
          fwd_ok   = (sb_addr[idx] == mem_addr) &&
                     (sb_size[idx] >= ld_size);
          fwd_data = sb_data[idx];
        end
      end
    end
  end

  assign can_fwd    = !io && hit && fwd_ok;
  assign blocked    = io ? !sb_empty : (hit && !fwd_ok);
  assign want_issue = is_load && !load_valid && !blocked && !can_fwd;
  assign load_go    = want_issue && state == IDLE && !busy;
  assign drain_go   = state == IDLE && !sb_empty && !busy && !want_issue;
  assign push       = is_store && count < (PW+1)'(SB_DEPTH);
  assign pop        = state == STORE_WAIT && mem_load_done;

  always_comb begin
    out_rd_addr      = input_rd_addr;
    out_rd_data      = input_rd_data;
    out_write_or_not = write_or_not;
    stall_from_mem   = 1'b0;
    if (rst_in) begin
      out_rd_addr      = '0;
      out_rd_data      = '0;
      out_write_or_not = 1'b0;
    end else if (!rdy_in) begin
      stall_from_mem = 1'b1;
    end else if (is_store) begin
      stall_from_mem = !push;
    end else if (is_load) begin
      if (load_valid)
        out_rd_data = result;
      else if (can_fwd && state == IDLE)
        out_rd_data = ext(cmdtype, fwd_data);
      else
        stall_from_mem = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state             <= IDLE;
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      load_valid        <= 1'b0;
      result            <= '0;
      ld_cmd            <= '0;
      read_mem          <= 1'b0;
      write_mem         <= 1'b0;
      mem_addr_to_read  <= '0;
      mem_data_to_write <= '0;
      data_len          <= '0;
    end else if (rdy_in) begin
      if (push) begin
        sb_addr[tail] <= mem_addr;
        sb_data[tail] <= storedata_in;
        sb_size[tail] <= st_size;
        tail          <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      count      <= count + (PW+1)'(push) - (PW+1)'(pop);
      load_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_go) begin
            read_mem         <= 1'b1;
            mem_addr_to_read <= mem_addr;
            data_len         <= ld_size;
            ld_cmd           <= cmdtype;
            state            <= LOAD_WAIT;
          end else if (drain_go) begin
            write_mem         <= 1'b1;
            mem_addr_to_read  <= sb_addr[head];
            mem_data_to_write <= sb_data[head];
            data_len          <= sb_size[head] - 3'd1;
            state             <= STORE_WAIT;
          end
        end
        LOAD_WAIT: begin
          if (mem_load_done) begin
            result     <= ext(ld_cmd, mem_ctrl_read_in);
            load_valid <= 1'b1;
            read_mem   <= 1'b0;
            state      <= IDLE;
          end
        end
        STORE_WAIT: begin
          if (mem_load_done) begin
            write_mem <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_store_buffer_lsu.sv
// Bench for mem_store_buffer_lsu: byte-level memory model plus a
// queue of posted stores, with the bench acting as memory controller.
module tb_mem_store_buffer_lsu;
  localparam int DEPTH = 4;
  localparam logic [3:0] NOP = 4'd0, LB = 4'd1, LH = 4'd2, LW = 4'd3;
  localparam logic [3:0] LBU = 4'd4, LHU = 4'd5;
  localparam logic [3:0] SB = 4'd6, SH = 4'd7, SW = 4'd8;

  logic        clk_in, rst_in, rdy_in;
  logic [3:0]  cmdtype;
  logic [4:0]  input_rd_addr, out_rd_addr;
  logic [31:0] input_rd_data, out_rd_data, mem_addr, storedata_in;
  logic        write_or_not, out_write_or_not, stall_from_mem, sb_empty;
  logic        mem_load_done, read_mem, write_mem;
  logic [1:0]  mem_ctrl_busy_state;
  logic [31:0] mem_ctrl_read_in, mem_addr_to_read, mem_data_to_write;
  logic [2:0]  data_len;

  mem_store_buffer_lsu #(.SB_DEPTH(DEPTH), .IO_BASE(32'h30000)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .cmdtype(cmdtype), .input_rd_addr(input_rd_addr),
    .input_rd_data(input_rd_data), .write_or_not(write_or_not),
    .mem_addr(mem_addr), .storedata_in(storedata_in),
    .out_rd_addr(out_rd_addr), .out_rd_data(out_rd_data),
    .out_write_or_not(out_write_or_not),
    .stall_from_mem(stall_from_mem), .sb_empty(sb_empty),
    .mem_load_done(mem_load_done),
    .mem_ctrl_busy_state(mem_ctrl_busy_state),
    .mem_ctrl_read_in(mem_ctrl_read_in), .read_mem(read_mem),
    .write_mem(write_mem), .mem_addr_to_read(mem_addr_to_read),
    .mem_data_to_write(mem_data_to_write), .data_len(data_len));

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          size;
  } st_t;

  st_t        q[$];
  logic [7:0] mem[logic [31:0]];
  int tests = 0, fails = 0, cyc = 0, lat = 0;
  logic        force_done = 1'b0, last_stall, saw_read, w_cap;
  logic [31:0] last_out, w_addr, rd_done_cyc, rd_qsize, ok_cyc;
  logic [2:0]  w_len, rd_len;

  function automatic int ld_sz(input logic [3:0] c);
    if (c == LB || c == LBU) return 1;
    if (c == LH || c == LHU) return 2;
    return 4;
  endfunction

  function automatic int st_sz(input logic [3:0] c);
    if (c == SB) return 1;
    if (c == SH) return 2;
    return 4;
  endfunction

  function automatic logic is_ld(input logic [3:0] c);
    return c >= LB && c <= LHU;
  endfunction

  function automatic logic is_st(input logic [3:0] c);
    return c >= SB && c <= SW;
  endfunction

  function automatic logic [31:0] ext_m(input logic [3:0] c,
                                        input logic [31:0] w);
    logic [31:0] r;
    r = w;
    if (c == LB)  r = (w & 32'hFF) - ((w & 32'h80) << 1);
    if (c == LH)  r = (w & 32'hFFFF) - ((w & 32'h8000) << 1);
    if (c == LBU) r = w & 32'hFF;
    if (c == LHU) r = w & 32'hFFFF;
    return r;
  endfunction

  function automatic logic [7:0] mem_b(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // Memory as the program sees it: drained bytes under posted stores.
  function automatic logic [31:0] view(input logic [31:0] a, input int n);
    logic [31:0] w;
    logic [7:0]  b;
    w = '0;
    for (int k = 0; k < n; k++) begin
      b = mem_b(a + 32'(k));
      foreach (q[j])
        if (a + 32'(k) >= q[j].addr && a + 32'(k) < q[j].addr + 32'(q[j].size))
          b = 8'(q[j].data >> (8 * (a + 32'(k) - q[j].addr)));
      w = w | (32'(b) << (8 * k));
    end
    return w;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < n; k++) w = w | (32'(mem_b(a + 32'(k))) << (8 * k));
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic tick();
    logic done, acc;
    logic [31:0] mask;
    st_t e;
    mem_load_done = force_done ||
      (!rst_in && (read_mem || write_mem) && lat >= 2);
    mem_ctrl_read_in = rd_word(mem_addr_to_read, int'(data_len));
    #2;
    done = mem_load_done && rdy_in && !rst_in;
    last_stall = stall_from_mem;
    last_out = out_rd_data;
    if (read_mem) saw_read = 1'b1;
    chk("sb_empty", 32'(sb_empty), 32'(q.size() == 0));
    if (rst_in) begin
      chk("rst_stall", 32'(stall_from_mem), 0);
      chk("rst_out_data", out_rd_data, 0);
      chk("rst_out_addr", 32'(out_rd_addr), 0);
      chk("rst_out_wen", 32'(out_write_or_not), 0);
    end else if (!rdy_in) begin
      chk("rdy_low_stall", 32'(stall_from_mem), 1);
    end else if (is_st(cmdtype)) begin
      chk("st_stall", 32'(stall_from_mem), 32'(q.size() >= DEPTH));
      if (!stall_from_mem)
        chk("st_wen", 32'(out_write_or_not), 32'(write_or_not));
    end else if (is_ld(cmdtype)) begin
      if (!stall_from_mem) begin
        chk("ld_data", out_rd_data,
            ext_m(cmdtype, view(mem_addr, ld_sz(cmdtype))));
        chk("ld_rd_addr", 32'(out_rd_addr), 32'(input_rd_addr));
      end
    end else begin
      chk("pt_stall", 32'(stall_from_mem), 0);
      chk("pt_data", out_rd_data, input_rd_data);
      chk("pt_addr", 32'(out_rd_addr), 32'(input_rd_addr));
      chk("pt_wen", 32'(out_write_or_not), 32'(write_or_not));
    end
    acc = is_st(cmdtype) && q.size() < DEPTH;
    if (done && write_mem) begin
      if (q.size() == 0) begin
        chk("write_with_empty_model", 1, 0);
      end else begin
        e = q[0];
        mask = e.size == 4 ? 32'hFFFFFFFF : e.size == 2 ? 32'hFFFF : 32'hFF;
        chk("wr_addr", mem_addr_to_read, e.addr);
        chk("wr_len", 32'(data_len), 32'(e.size - 1));
        chk("wr_data", mem_data_to_write & mask, e.data & mask);
        if (!w_cap) begin
          w_cap = 1'b1; w_addr = mem_addr_to_read; w_len = data_len;
        end
        for (int k = 0; k < e.size; k++)
          mem[e.addr + 32'(k)] = 8'(e.data >> (8 * k));
      end
    end
    if (done && read_mem) begin
      chk("rd_addr", mem_addr_to_read, mem_addr);
      chk("rd_len", 32'(data_len), 32'(ld_sz(cmdtype)));
      rd_done_cyc = 32'(cyc); rd_qsize = 32'(q.size()); rd_len = data_len;
    end
    if (rst_in) begin
      q.delete(); lat = 0;
    end else if (rdy_in) begin
      if (done && write_mem && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back('{mem_addr, storedata_in, st_sz(cmdtype)});
      if (read_mem || write_mem) lat = done ? 0 : lat + 1;
    end
    ok_cyc = 32'(cyc);
    @(posedge clk_in);
    @(negedge clk_in);
    cyc++;
  endtask

  task automatic op(input logic [3:0] c, input logic [31:0] a,
                    input logic [31:0] d, output int n);
    cmdtype = c; mem_addr = a; storedata_in = d;
    input_rd_addr = 5'd9; input_rd_data = 32'h0BAD_0BAD;
    write_or_not = is_ld(c);
    n = 0;
    do begin tick(); n++; end while (last_stall && n < 60);
    if (last_stall) chk("op_timeout", 32'(n), 0);
    cmdtype = NOP;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || write_mem || read_mem) && n < 100) begin
      tick(); n++;
    end
    chk("drain_timeout", 32'(q.size() != 0 || write_mem), 0);
  endtask

  task automatic put_word(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) mem[a + 32'(k)] = 8'(w >> (8 * k));
  endtask

  initial begin
    int n, n1;
    rst_in = 1'b1; rdy_in = 1'b1; cmdtype = NOP; mem_addr = '0;
    storedata_in = '0; input_rd_addr = '0; input_rd_data = '0;
    write_or_not = 1'b0; mem_load_done = 1'b0; mem_ctrl_busy_state = 2'b00;
    mem_ctrl_read_in = '0; saw_read = 1'b0; w_cap = 1'b0;
    @(negedge clk_in);
    tick(); tick();
    rst_in = 1'b0;
    chk("reset_read_mem", 32'(read_mem), 0);
    chk("reset_write_mem", 32'(write_mem), 0);
    chk("reset_sb_empty", 32'(sb_empty), 1);
    chk("reset_addr", mem_addr_to_read, 0);
    chk("reset_len", 32'(data_len), 0);

    input_rd_addr = 5'd7; input_rd_data = 32'hA5A5_5A5A; write_or_not = 1'b1;
    tick();
    input_rd_addr = 5'd31; input_rd_data = 32'h0000_0001; write_or_not = 1'b0;
    tick();

    // store then forwarded byte load, back-to-back
    saw_read = 1'b0;
    op(SW, 32'h100, 32'hDEAD_BEEF, n1);
    op(LB, 32'h100, 0, n);
    chk("sw_cycles", 32'(n1), 1);
    chk("lb_fwd_cycles", 32'(n), 1);
    chk("lb_fwd_data", last_out, 32'hFFFF_FFEF);
    chk("lb_fwd_no_read", 32'(saw_read), 0);
    drain();

    // partial overlap: store drains before the load reads
    put_word(32'h104, 32'h1234_ABCD);
    w_cap = 1'b0; saw_read = 1'b0;
    op(SB, 32'h141, 32'h7F, n1);
    op(LW, 32'h140, 0, n);
    chk("sb_lw_data", last_out, 32'h0000_7F00);
    chk("sb_lw_stalled", 32'(n > 1), 1);
    chk("sb_drain_addr", w_addr, 32'h141);
    chk("sb_drain_len", 32'(w_len), 0);
    chk("lw_read_seen", 32'(saw_read), 1);
    chk("lw_read_len", 32'(rd_len), 4);
    op(LHU, 32'h104, 0, n);
    chk("lhu_data", last_out, 32'h0000_ABCD);
    op(LB, 32'h107, 0, n);
    chk("lb_pos_data", last_out, 32'h0000_0012);
    op(LB, 32'h105, 0, n);
    chk("lb_neg_data", last_out, 32'hFFFF_FFAB);

    // halfword forwarding and narrower/wider follow-ups
    op(SH, 32'h110, 32'h0000_8001, n1);
    op(LH, 32'h110, 0, n);
    chk("lh_fwd_cycles", 32'(n), 1);
    chk("lh_fwd_data", last_out, 32'hFFFF_8001);
    op(LBU, 32'h110, 0, n);
    chk("lbu_data", last_out, 32'h0000_0001);
    op(LW, 32'h110, 0, n);
    chk("lw_after_sh", last_out, 32'h0000_8001);
    drain();

    // fill the buffer while the controller is busy
    mem_ctrl_busy_state = 2'b10;
    for (int i = 0; i < DEPTH; i++) begin
      op(SW, 32'h200 + 32'(4 * i), 32'(i + 1), n);
      chk("fill_cycles", 32'(n), 1);
    end
    cmdtype = SW; mem_addr = 32'h210; storedata_in = 32'h55;
    write_or_not = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_stall", 32'(last_stall), 1);
    end
    mem_ctrl_busy_state = 2'b00;
    op(SW, 32'h210, 32'h55, n);
    chk("full_release_cycles", 32'(n), 5);
    drain();

    // IO load ordered behind a buffered store
    put_word(32'h30000, 32'hCAFE_F00D);
    op(SW, 32'h200, 32'h66, n1);
    op(LW, 32'h30000, 0, n);
    chk("io_data", last_out, 32'hCAFE_F00D);
    chk("io_qsize_at_read", rd_qsize, 0);
    chk("io_result_latency", ok_cyc - rd_done_cyc, 1);

    // rdy_in low freezes a store drain in flight
    op(SW, 32'h300, 32'h77, n1);
    n = 0;
    while (!write_mem && n < 10) begin tick(); n++; end
    chk("store_wait_reached", 32'(write_mem), 1);
    rdy_in = 1'b0; force_done = 1'b1;
    tick();
    force_done = 1'b0;
    chk("frozen_stall", 32'(last_stall), 1);
    chk("frozen_sb_empty", 32'(sb_empty), 0);
    chk("frozen_write_mem", 32'(write_mem), 1);
    tick();
    rdy_in = 1'b1;
    op(SW, 32'h304, 32'h88, n);
    chk("enq_during_drain", 32'(n), 1);
    drain();

    // reset while a load is outstanding
    mem_ctrl_busy_state = 2'b10;
    op(SW, 32'h500, 32'h99, n1);
    mem_ctrl_busy_state = 2'b00;
    cmdtype = LW; mem_addr = 32'h400; write_or_not = 1'b1;
    n = 0;
    while (!read_mem && n < 10) begin tick(); n++; end
    chk("load_wait_reached", 32'(read_mem), 1);
    rst_in = 1'b1;
    tick();
    chk("rst_mid_stall", 32'(last_stall), 0);
    rst_in = 1'b0; cmdtype = NOP;
    chk("rst_mid_read_mem", 32'(read_mem), 0);
    chk("rst_mid_sb_empty", 32'(sb_empty), 1);
    chk("rst_mid_write_mem", 32'(write_mem), 0);
    op(LW, 32'h100, 0, n);
    chk("post_reset_lw", last_out, 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
